// File: rtl/mm_pkg.sv
// Shared types and defaults for the matrix-multiply BRAM sequencer.
// Matrices are row-major: element (i,j) sits at flat index i*N+j.
package mm_pkg;

    localparam int N_DEF  = 2;
    localparam int DW_DEF = 32;
    localparam int AW_DEF = 13;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_X    = 3'd1,
        RD_Y    = 3'd2,
        COMPUTE = 3'd3,
        WR      = 3'd4,
        DONE    = 3'd5
    } state_t;

    function automatic int elem_idx(input int i, input int j, input int n);
        return i * n + j;
    endfunction

endpackage

// File: rtl/mm_bram_rd_slot.sv
// Issue/wait/capture timer for one BRAM read: one issue cycle, then RD_LAT
// wait cycles, with capture asserted on the last wait cycle.
module mm_bram_rd_slot #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    output logic issue,
    output logic capture
);

    localparam int CW = $clog2(RD_LAT + 1);

    logic [CW-1:0] cnt;

    assign issue   = go && (cnt == '0);
    assign capture = go && (cnt == CW'(RD_LAT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!go || capture) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mm_bram_sequencer.sv
// Job sequencer owning the accelerator's single BRAM port: fetch X and Y,
// run the multiply core, then write OUT back. The core never sees BRAM.
module mm_bram_sequencer
    import mm_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DW      = DW_DEF,
    parameter int AW      = AW_DEF,
    parameter int RD_LAT  = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW-1:0]     x_base,
    input  logic [AW-1:0]     y_base,
    input  logic [AW-1:0]     out_base,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AW-1:0]     bram_addr,
    output logic              bram_clk,
    output logic [DW-1:0]     bram_din,
    input  logic [DW-1:0]     bram_dout,
    output logic              bram_en,
    output logic              bram_we,
    output logic [N*N*DW-1:0] core_x,
    output logic [N*N*DW-1:0] core_y,
    output logic              core_rst,
    input  logic [N*N*DW-1:0] core_out,
    input  logic              core_done,
    output logic [2:0]        dbg_state
);

    localparam int NN = N * N;
    localparam int IW = $clog2(NN + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            state, state_nxt;
    logic [IW-1:0]     idx;
    logic [TW-1:0]     tmo_ctr;
    logic [AW-1:0]     x_base_q, y_base_q, out_base_q;
    logic [NN*DW-1:0]  x_q, y_q, res_q;
    logic              rd_go, rd_issue, rd_capture;
    logic              last_elem, tmo_hit;

    assign rd_go     = (state == RD_X) || (state == RD_Y);
    assign last_elem = (idx == IW'(NN - 1));
    assign tmo_hit   = (tmo_ctr == TW'(TIMEOUT - 1));

    mm_bram_rd_slot #(.RD_LAT(RD_LAT)) u_rd_slot (
        .clk     (clk),
        .rst     (rst),
        .go      (rd_go),
        .issue   (rd_issue),
        .capture (rd_capture)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RD_X;
            RD_X:    if (rd_capture && last_elem) state_nxt = RD_Y;
            RD_Y:    if (rd_capture && last_elem) state_nxt = COMPUTE;
            COMPUTE: if (core_done) state_nxt = WR;
                     else if (tmo_hit) state_nxt = DONE;
            WR:      if (last_elem) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            tmo_ctr    <= '0;
            err        <= 1'b0;
            x_base_q   <= '0;
            y_base_q   <= '0;
            out_base_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            res_q      <= '0;
        end else begin
            state   <= state_nxt;
            tmo_ctr <= (state == COMPUTE) ? tmo_ctr + 1'b1 : '0;
            case (state)
                IDLE: begin
                    idx <= '0;
                    if (start) begin
                        x_base_q   <= x_base;
                        y_base_q   <= y_base;
                        out_base_q <= out_base;
                        err        <= 1'b0;
                    end
                end
                RD_X, RD_Y: begin
                    if (rd_capture) begin
                        if (state == RD_X) x_q[int'(idx)*DW +: DW] <= bram_dout;
                        else               y_q[int'(idx)*DW +: DW] <= bram_dout;
                        idx <= last_elem ? '0 : idx + 1'b1;
                    end
                end
                COMPUTE: begin
                    idx <= '0;
                    // core_done wins over a timeout landing on the same cycle
                    if (core_done)    res_q <= core_out;
                    else if (tmo_hit) err   <= 1'b1;
                end
                WR:      idx <= last_elem ? '0 : idx + 1'b1;
                default: idx <= '0;
            endcase
        end
    end

    always_comb begin
        bram_en   = 1'b0;
        bram_we   = 1'b0;
        bram_addr = '0;
        bram_din  = '0;
        case (state)
            RD_X: begin
                bram_en   = rd_issue;
                bram_addr = x_base_q + AW'(idx);
            end
            RD_Y: begin
                bram_en   = rd_issue;
                bram_addr = y_base_q + AW'(idx);
            end
            WR: begin
                bram_en   = 1'b1;
                bram_we   = 1'b1;
                bram_addr = out_base_q + AW'(idx);
                bram_din  = res_q[int'(idx)*DW +: DW];
            end
            default: ;
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign core_rst  = (state != COMPUTE);
    assign core_x    = x_q;
    assign core_y    = y_q;
    assign bram_clk  = clk;
    assign dbg_state = state;

endmodule
